// File: rtl/ula_multicycle_ctrl.sv
// Moore FSM control unit for the multicycle MIPS datapath (feeds the ULA).
// It steps each instruction through FETCH, DECODE, execute and writeback.
// It drives the mux selects, the write enables, ULAcontrol and PCEn.
// Optional feature: define BNE_EN to add bne (opcode 000101) through BRANCH.
module ula_multicycle_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       Z,
    output logic [2:0] ULAcontrol,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t     state_q, state_d;
    logic       funct_legal;
    logic [2:0] funct_ula;
    logic       is_bne;

`ifdef BNE_EN
    localparam logic [5:0] OP_BNE = 6'b000101;
    assign is_bne = (opcode == OP_BNE);
`else
    assign is_bne = 1'b0;
`endif

    assign state_o = state_q;

    // Map the R-type funct field to a ULA opcode and flag unsupported ones.
    always_comb begin
        funct_legal = 1'b1;
        funct_ula   = 3'b000;
        case (funct)
            6'b100000: funct_ula = 3'b000;
            6'b100010: funct_ula = 3'b001;
            6'b100100: funct_ula = 3'b010;
            6'b100101: funct_ula = 3'b011;
            6'b101010: funct_ula = 3'b101;
            default:   funct_legal = 1'b0;
        endcase
    end

    // State register; the asynchronous reset forces FETCH at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    // Next-state logic; unknown opcodes and illegal functs go back to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = funct_legal ? S_EXEC : S_FETCH;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = is_bne ? S_BRANCH : S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Moore outputs per state; the enables are forced low while reset is held.
    always_comb begin
        ULAcontrol = 3'b000;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        PCSrc      = 2'b00;
        PCEn       = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB = 2'b01;
                IRWrite = 1'b1;
                PCEn    = 1'b1;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA    = 1'b1;
                ULAcontrol = funct_ula;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ULAcontrol = 3'b001;
                PCSrc      = 2'b01;
                PCEn       = is_bne ? ~Z : Z;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc = 2'b10;
                PCEn  = 1'b1;
            end
            default: ;
        endcase
        if (!reset_n) begin
            PCEn     = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

endmodule
